// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter for PTW, DMEM and IF masters; one transaction in flight.
// Optional build macro ARB_ROUND_ROBIN_EN swaps fixed priority + IF starvation guard for rotating priority.

package mem_port_arbiter_pkg;
    localparam logic [1:0] MSIZE8 = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  ptw_req,
    input  dbus_req_t  dm_req,
    input  ibus_req_t  if_req,
    output dbus_resp_t ptw_resp,
    output dbus_resp_t dm_resp,
    output ibus_resp_t if_resp,
    output dbus_req_t  mreq,
    input  dbus_resp_t mresp,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_PTW = 2'd0;
    localparam logic [1:0] OWN_DM  = 2'd1;
    localparam logic [1:0] OWN_IF  = 2'd2;

    state_t     state, state_nx;
    logic [1:0] owner;
    logic [1:0] winner;
    logic       arb_go;
    dbus_req_t  if_conv;
    dbus_req_t  win_req;
    dbus_req_t  lat_req;
    dbus_resp_t fwd;

    always_comb begin
        if_conv       = '0;
        if_conv.valid = if_req.valid;
        if_conv.addr  = if_req.addr;
        if_conv.size  = MSIZE8;
    end

    // Arbitration only happens from IDLE, so a held valid is never granted twice mid-flight.
    assign arb_go = (state == IDLE) && (ptw_req.valid || dm_req.valid || if_req.valid);

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_grant;

    always_comb begin
        winner = OWN_PTW;
        case (last_grant)
            OWN_PTW: begin
                if (dm_req.valid)       winner = OWN_DM;
                else if (if_req.valid)  winner = OWN_IF;
                else                    winner = OWN_PTW;
            end
            OWN_DM: begin
                if (if_req.valid)       winner = OWN_IF;
                else if (ptw_req.valid) winner = OWN_PTW;
                else                    winner = OWN_DM;
            end
            default: begin
                if (ptw_req.valid)      winner = OWN_PTW;
                else if (dm_req.valid)  winner = OWN_DM;
                else                    winner = OWN_IF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         last_grant <= OWN_IF;
        else if (arb_go) last_grant <= winner;
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    always_comb begin
        winner = OWN_IF;
        if (if_req.valid && (starve_cnt == LIMIT)) winner = OWN_IF;
        else if (ptw_req.valid)                   winner = OWN_PTW;
        else if (dm_req.valid)                    winner = OWN_DM;
    end

    // Counts grants IF lost while waiting; saturates so the override stays armed.
    always_ff @(posedge clk) begin
        if (rst || !if_req.valid) begin
            starve_cnt <= '0;
        end else if (arb_go) begin
            if (winner == OWN_IF)        starve_cnt <= '0;
            else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    always_comb begin
        case (winner)
            OWN_PTW: win_req = ptw_req;
            OWN_DM:  win_req = dm_req;
            default: win_req = if_conv;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arb_go) state_nx = GRANT;
            GRANT:   if (mresp.addr_ok) state_nx = mresp.data_ok ? IDLE : WAIT;
            WAIT:    if (mresp.data_ok) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_PTW;
        end else begin
            state <= state_nx;
            if (arb_go) owner <= winner;
        end
    end

    // Request payload is frozen at grant time; it is only visible on mreq during GRANT.
    always_ff @(posedge clk) begin
        if (arb_go) lat_req <= win_req;
    end

    always_comb begin
        mreq = '0;
        if (state == GRANT) begin
            mreq       = lat_req;
            mreq.valid = 1'b1;
        end
    end

    always_comb begin
        fwd      = '0;
        ptw_resp = '0;
        dm_resp  = '0;
        if_resp  = '0;
        if (state != IDLE) begin
            fwd.addr_ok = mresp.addr_ok && (state == GRANT);
            fwd.data_ok = mresp.data_ok;
            fwd.data    = mresp.data;
        end
        case (owner)
            OWN_PTW: ptw_resp = fwd;
            OWN_DM:  dm_resp  = fwd;
            OWN_IF: begin
                if_resp.addr_ok = fwd.addr_ok;
                if_resp.data_ok = fwd.data_ok;
                if_resp.data    = fwd.data;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations; define ARB_ROUND_ROBIN_EN to match the DUT build.

module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 8;

    logic       clk = 1'b0;
    logic       rst;
    dbus_req_t  ptw_req, dm_req, mreq;
    ibus_req_t  if_req;
    dbus_resp_t ptw_resp, dm_resp, mresp;
    ibus_resp_t if_resp;
    logic       busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ptw_req(ptw_req), .dm_req(dm_req), .if_req(if_req),
        .ptw_resp(ptw_resp), .dm_resp(dm_resp), .if_resp(if_resp),
        .mreq(mreq), .mresp(mresp), .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stimulus controls (owned by the main sequence)
    bit          auto_en = 0;
    bit          use_fixed = 0;
    bit          spur = 0;
    bit          chk_en = 0;
    int          adly = 1;
    int          ddly = 2;
    logic [31:0] q0[$], q1[$], q2[$];

    // Requester state (owned by the driver)
    bit          cur_v[3];
    logic [31:0] cur_a[3];
    int          consumed[3];

    // Observations (owned by the monitor)
    int          cyc = 0;
    int          busy_cyc = 0;
    int          dok_cnt[3];
    int          both_cnt[3];
    logic [63:0] last_data[3];
    logic [31:0] glog[$];
    logic [1:0]  gsize[$];
    int          gcyc[$];
    int          rcyc[$];

    function automatic int qsize(int r);
        case (r)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Requesters: hold valid until own data_ok, then present next queued address at once.
    initial begin
        ptw_req = '0; dm_req = '0; if_req = '0;
        for (int r = 0; r < 3; r++) begin cur_v[r] = 0; cur_a[r] = '0; consumed[r] = 0; end
        forever begin
            @(posedge clk); #2;
            for (int r = 0; r < 3; r++) begin
                if (rst) begin
                    cur_v[r] = 0;
                    consumed[r] = dok_cnt[r];
                end else begin
                    if (consumed[r] != dok_cnt[r]) begin
                        cur_v[r] = 0;
                        consumed[r] = dok_cnt[r];
                    end
                    if (!cur_v[r] && auto_en && qsize(r) > 0) begin
                        case (r)
                            0: cur_a[r] = q0.pop_front();
                            1: cur_a[r] = q1.pop_front();
                            default: cur_a[r] = q2.pop_front();
                        endcase
                        cur_v[r] = 1;
                    end
                end
            end
            ptw_req = '{valid: cur_v[0], addr: cur_a[0], size: MSIZE8, strobe: 8'h00, data: 64'h0};
            dm_req  = '{valid: cur_v[1], addr: cur_a[1], size: 2'd2, strobe: 8'h0F,
                        data: {32'h0, cur_a[1] ^ 32'h5A5A_0000}};
            if_req  = '{valid: cur_v[2], addr: cur_a[2]};
        end
    end

    // Memory port: addr_ok adly cycles and data_ok ddly cycles after the request first appears.
    initial begin
        int k;
        logic [31:0] cur_addr;
        k = -1;
        cur_addr = '0;
        mresp = '0;
        forever begin
            @(posedge clk); #3;
            if (rst) begin
                k = -1;
                mresp = '0;
            end else begin
                if (k >= ddly) k = -1;
                if (k < 0 && mreq.valid) begin
                    k = 0;
                    cur_addr = mreq.addr;
                end else if (k >= 0) begin
                    k++;
                end
                mresp = '0;
                if (k >= 0 && k == adly) mresp.addr_ok = 1'b1;
                if (k >= 0 && k == ddly) begin
                    mresp.data_ok = 1'b1;
                    mresp.data = use_fixed ? 64'h1234 : {32'hCAFE_0000, cur_addr};
                end
                if (spur) begin
                    mresp.data_ok = 1'b1;
                    mresp.data = 64'hDEAD_BEEF;
                end
            end
        end
    end

    // Reference model: one transaction record, winner chosen from the priority rules.
    bit        m_active = 0;
    bit        m_acc = 0;
    int        m_owner = 0;
    int        m_cnt = 0;
    int        m_last = 2;
    dbus_req_t m_req = '0;

    function automatic int pick_winner(bit v0, bit v1, bit v2);
        bit v[3];
        int order[3];
        v[0] = v0; v[1] = v1; v[2] = v2;
        for (int k = 0; k < 3; k++) order[k] = k;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) order[k] = (m_last + 1 + k) % 3;
`else
        if (v[2] && m_cnt == STARVE_LIMIT) return 2;
`endif
        for (int k = 0; k < 3; k++) if (v[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic dbus_req_t req_of(int w);
        dbus_req_t r;
        r = '0;
        case (w)
            0: r = ptw_req;
            1: r = dm_req;
            default: begin
                r.valid = if_req.valid;
                r.addr = if_req.addr;
                r.size = 2'd3;
            end
        endcase
        return r;
    endfunction

    function automatic logic [65:0] resp_of(int r);
        case (r)
            0: return {ptw_resp.addr_ok, ptw_resp.data_ok, ptw_resp.data};
            1: return {dm_resp.addr_ok, dm_resp.data_ok, dm_resp.data};
            default: return {if_resp.addr_ok, if_resp.data_ok, if_resp.data};
        endcase
    endfunction

    initial begin
        bit prev_mv, prev_any, anyv;
        prev_mv = 0; prev_any = 0;
        for (int r = 0; r < 3; r++) begin dok_cnt[r] = 0; both_cnt[r] = 0; last_data[r] = '0; end
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_en) begin
                dbus_req_t e_mreq;
                logic [65:0] e_resp;
                e_mreq = '0;
                if (m_active && !m_acc) begin
                    e_mreq = m_req;
                    e_mreq.valid = 1'b1;
                end
                chk("busy", 128'(busy), 128'(m_active));
                chk("mreq", 128'(mreq), 128'(e_mreq));
                for (int r = 0; r < 3; r++) begin
                    e_resp = '0;
                    if (m_active && m_owner == r) begin
                        e_resp[65] = !m_acc && mresp.addr_ok;
                        e_resp[64] = mresp.data_ok;
                        e_resp[63:0] = mresp.data;
                    end
                    chk($sformatf("resp%0d", r), 128'(resp_of(r)), 128'(e_resp));
                end
            end

            if (busy) busy_cyc++;
            if (mreq.valid && !prev_mv) begin
                glog.push_back(mreq.addr);
                gsize.push_back(mreq.size);
                gcyc.push_back(cyc);
            end
            prev_mv = mreq.valid;
            anyv = ptw_req.valid || dm_req.valid || if_req.valid;
            if (anyv && !prev_any) rcyc.push_back(cyc);
            prev_any = anyv;
            for (int r = 0; r < 3; r++) begin
                logic [65:0] rv;
                rv = resp_of(r);
                if (rv[64]) begin
                    dok_cnt[r]++;
                    last_data[r] = rv[63:0];
                    if (rv[65]) both_cnt[r]++;
                end
            end

            if (rst) begin
                m_active = 0; m_acc = 0; m_owner = 0; m_cnt = 0; m_last = 2;
            end else begin
                int w;
                w = -1;
                if (!m_active) begin
                    w = pick_winner(ptw_req.valid, dm_req.valid, if_req.valid);
                    if (w >= 0) begin
                        m_owner = w;
                        m_req = req_of(w);
                        m_active = 1;
                        m_acc = 0;
                    end
                end else begin
                    if (!m_acc && mresp.addr_ok) m_acc = 1;
                    if (m_acc && mresp.data_ok) m_active = 0;
                end
                if (!if_req.valid) m_cnt = 0;
                else if (w == 2) m_cnt = 0;
                else if (w >= 0 && m_cnt < STARVE_LIMIT) m_cnt++;
                if (w >= 0) m_last = w;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; auto_en = 0; spur = 0;
        q0.delete(); q1.delete(); q2.delete();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic wait_idle(input string nm, input int max_cyc);
        bit done;
        done = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
                !cur_v[0] && !cur_v[1] && !cur_v[2] && !busy) begin
                done = 1;
                break;
            end
        end
        chk({nm, "_done"}, 128'(done), 128'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int b_busy, b_log, b_rq;
        int b_dok[3];
        int b_both[3];
        bit got_wait;

        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_mreq", 128'(mreq), 128'(0));
        chk("rst_resp", 128'({ptw_resp, dm_resp, if_resp}), 128'(0));

        // Single fetch: addr_ok one cycle into GRANT, data_ok three cycles in.
        @(posedge clk); #1;
        b_busy = busy_cyc; b_log = glog.size(); b_rq = rcyc.size();
        for (int r = 0; r < 3; r++) b_dok[r] = dok_cnt[r];
        adly = 1; ddly = 3; use_fixed = 1;
        q2.push_back(32'h8000_0000);
        auto_en = 1;
        wait_idle("t1", 40);
        chk("t1_busy_cycles", 128'(busy_cyc - b_busy), 128'(4));
        chk("t1_if_dok", 128'(dok_cnt[2] - b_dok[2]), 128'(1));
        chk("t1_if_data", 128'(last_data[2]), 128'(64'h1234));
        chk("t1_others_dok", 128'((dok_cnt[0] - b_dok[0]) + (dok_cnt[1] - b_dok[1])), 128'(0));
        chk("t1_mreq_addr", 128'(glog[b_log]), 128'(32'h8000_0000));
        chk("t1_mreq_size", 128'(gsize[b_log]), 128'(2'd3));
        chk("t1_latency", 128'(gcyc[b_log] - rcyc[b_rq]), 128'(1));

        // All three request together: PTW, DM, IF back to back.
        do_reset();
        b_log = glog.size();
        for (int r = 0; r < 3; r++) b_dok[r] = dok_cnt[r];
        adly = 1; ddly = 2; use_fixed = 0;
        q0.push_back(32'h0000_0100);
        q1.push_back(32'h0000_0200);
        q2.push_back(32'h8000_0040);
        auto_en = 1;
        wait_idle("t2", 60);
        chk("t2_grants", 128'(glog.size() - b_log), 128'(3));
        chk("t2_order0", 128'(glog[b_log]), 128'(32'h0000_0100));
        chk("t2_order1", 128'(glog[b_log + 1]), 128'(32'h0000_0200));
        chk("t2_order2", 128'(glog[b_log + 2]), 128'(32'h8000_0040));
        chk("t2_dm_data", 128'(last_data[1]), 128'(64'hCAFE_0000_0000_0200));
        chk("t2_ptw_dok", 128'(dok_cnt[0] - b_dok[0]), 128'(1));

`ifndef ARB_ROUND_ROBIN_EN
        // DM always valid, IF waiting; same-cycle addr_ok+data_ok in GRANT.
        do_reset();
        b_log = glog.size(); b_busy = busy_cyc;
        for (int r = 0; r < 3; r++) b_both[r] = both_cnt[r];
        adly = 0; ddly = 0;
        for (int i = 0; i < 10; i++) q1.push_back(32'h300 + 32'(i * 8));
        q2.push_back(32'h8000_0100);
        auto_en = 1;
        wait_idle("t3", 80);
        chk("t3_grants", 128'(glog.size() - b_log), 128'(11));
        chk("t3_grant8_dm", 128'(glog[b_log + 7]), 128'(32'h338));
        chk("t3_grant9_if", 128'(glog[b_log + 8]), 128'(32'h8000_0100));
        chk("t3_grant10_dm", 128'(glog[b_log + 9]), 128'(32'h340));
        chk("t3_busy_cycles", 128'(busy_cyc - b_busy), 128'(11));
        chk("t3_dm_both", 128'(both_cnt[1] - b_both[1]), 128'(10));
        chk("t3_if_both", 128'(both_cnt[2] - b_both[2]), 128'(1));
`else
        // Rotating priority with everyone continuously requesting.
        do_reset();
        b_log = glog.size();
        adly = 1; ddly = 1;
        q0.push_back(32'h110); q0.push_back(32'h120);
        q1.push_back(32'h210); q1.push_back(32'h220);
        q2.push_back(32'h8000_0310); q2.push_back(32'h8000_0320);
        auto_en = 1;
        wait_idle("t3", 80);
        chk("t3_grants", 128'(glog.size() - b_log), 128'(6));
        chk("t3_rr0", 128'(glog[b_log]), 128'(32'h110));
        chk("t3_rr1", 128'(glog[b_log + 1]), 128'(32'h210));
        chk("t3_rr2", 128'(glog[b_log + 2]), 128'(32'h8000_0310));
        chk("t3_rr3", 128'(glog[b_log + 3]), 128'(32'h120));
        chk("t3_rr4", 128'(glog[b_log + 4]), 128'(32'h220));
        chk("t3_rr5", 128'(glog[b_log + 5]), 128'(32'h8000_0320));
`endif

        // Reset while in WAIT, then a stray data_ok while IDLE.
        do_reset();
        for (int r = 0; r < 3; r++) b_dok[r] = dok_cnt[r];
        adly = 0; ddly = 4;
        q1.push_back(32'h500);
        auto_en = 1;
        got_wait = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy && !mreq.valid) begin
                got_wait = 1;
                break;
            end
        end
        chk("t5_reached_wait", 128'(got_wait), 128'(1));
        @(posedge clk); #1;
        rst = 1; auto_en = 0; q1.delete();
        @(posedge clk); #1;
        rst = 0; spur = 1;
        @(negedge clk);
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_mreq_valid", 128'(mreq.valid), 128'(0));
        chk("t5_resp_dok", 128'({ptw_resp.data_ok, dm_resp.data_ok, if_resp.data_ok}), 128'(0));
        @(posedge clk); #1;
        spur = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_dok", 128'(dok_cnt[0] + dok_cnt[1] + dok_cnt[2] - b_dok[0] - b_dok[1] - b_dok[2]), 128'(0));
        chk("t5_idle", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
